door_sensor_conditioner: RTL and testbench

//  Front end that feeds the automatic door controller.

---
 rtl/door_pkg.sv | 13 +
 rtl/door_sensor_conditioner_if.sv | 18 +
 rtl/sensor_debounce.sv | 51 +++++
 rtl/door_sensor_conditioner.sv | 93 +++++++++
 tb/tb_door_sensor_conditioner.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/door_pkg.sv
// rtl/door_pkg.sv - shared lock-state encoding and default timing constants for the door sensor front end
package door_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        PEND     = 2'b01,
        LOCKED   = 2'b10
    } lock_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_FAULT_CYCLES    = 8;

endpackage

// File: rtl/door_sensor_conditioner_if.sv
// rtl/door_sensor_conditioner_if.sv - raw sensor inputs and conditioned outputs of the door front end
interface door_sensor_conditioner_if;

    logic pa_raw, pp_raw, mo_raw, r_raw, l_raw, m_raw, lk_raw;
    logic pa, pp, mo, r, l, m;
    logic mo_pulse, lk, lk_pending, limit_fault;

    modport master (
        output pa_raw, pp_raw, mo_raw, r_raw, l_raw, m_raw, lk_raw,
        input  pa, pp, mo, r, l, m, mo_pulse, lk, lk_pending, limit_fault
    );

    modport slave (
        input  pa_raw, pp_raw, mo_raw, r_raw, l_raw, m_raw, lk_raw,
        output pa, pp, mo, r, l, m, mo_pulse, lk, lk_pending, limit_fault
    );

endinterface

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - one channel: 2-flop synchroniser followed by a stable-count debouncer
module sensor_debounce
    import door_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       out_q, out_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        out_d   = out_q;
        cnt_d   = 8'd0;
        // Any cycle where the synced input agrees with the output restarts the count.
        if (sync2_q != out_q) begin
            if (cnt_q == CNT_LAST) begin
                out_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            out_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = out_q;

endmodule

// File: rtl/door_sensor_conditioner.sv
// rtl/door_sensor_conditioner.sv - debounces door sensors, pulses manual-open, qualifies lock, flags bad limits
module door_sensor_conditioner
    import door_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FAULT_CYCLES    = DEFAULT_FAULT_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    door_sensor_conditioner_if.slave   bus
);

    localparam logic [7:0] FAULT_LAST = 8'(FAULT_CYCLES - 1);
    localparam logic [7:0] FAULT_MAX  = 8'(FAULT_CYCLES);

    logic [6:0] raw_vec, db_vec;
    logic       pa_db, pp_db, mo_db, r_db, l_db, m_db, lk_db;

    assign raw_vec = {bus.lk_raw, bus.m_raw, bus.l_raw, bus.r_raw,
                      bus.mo_raw, bus.pp_raw, bus.pa_raw};

    for (genvar i = 0; i < 7; i++) begin : g_ch
        sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_vec[i]),
            .db    (db_vec[i])
        );
    end

    assign {lk_db, m_db, l_db, r_db, mo_db, pp_db, pa_db} = db_vec;

    lock_state_e state_q, state_d;
    logic        mo_prev_q, mo_prev_d;
    logic        mo_pulse_q, mo_pulse_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        fault_q, fault_d;
    logic        grant, illegal;

    always_comb begin
        grant   = m_db & ~pp_db & ~pa_db;
        state_d = state_q;
        // Switch release is tested first so it beats a simultaneous grant.
        case (state_q)
            UNLOCKED: if (lk_db) state_d = grant ? LOCKED : PEND;
            PEND: begin
                if (!lk_db)     state_d = UNLOCKED;
                else if (grant) state_d = LOCKED;
            end
            LOCKED:   if (!lk_db) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
        endcase

        mo_prev_d  = mo_db;
        mo_pulse_d = mo_db & ~mo_prev_q;

        illegal = m_db & (r_db | l_db);
        fcnt_d  = 8'd0;
        fault_d = fault_q;
        if (illegal) begin
            if (fcnt_q >= FAULT_LAST) fault_d = 1'b1;
            fcnt_d = (fcnt_q == FAULT_MAX) ? fcnt_q : fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            mo_prev_q  <= 1'b0;
            mo_pulse_q <= 1'b0;
            fcnt_q     <= 8'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mo_prev_q  <= mo_prev_d;
            mo_pulse_q <= mo_pulse_d;
            fcnt_q     <= fcnt_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.pa          = pa_db;
    assign bus.pp          = pp_db;
    assign bus.mo          = mo_db;
    assign bus.r           = r_db;
    assign bus.l           = l_db;
    assign bus.m           = m_db;
    assign bus.mo_pulse    = mo_pulse_q;
    assign bus.lk          = (state_q == LOCKED);
    assign bus.lk_pending  = (state_q == PEND);
    assign bus.limit_fault = fault_q;

endmodule

// File: tb/tb_door_sensor_conditioner.sv
// tb/tb_door_sensor_conditioner.sv - directed self-checking bench for door_sensor_conditioner
module tb_door_sensor_conditioner;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    door_sensor_conditioner_if dif ();

    door_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .FAULT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [9:0] outs();
        outs = {dif.pa, dif.pp, dif.mo, dif.r, dif.l, dif.m,
                dif.mo_pulse, dif.lk, dif.lk_pending, dif.limit_fault};
    endfunction

    task automatic set_raw(input logic [6:0] v);
        {dif.lk_raw, dif.m_raw, dif.l_raw, dif.r_raw, dif.mo_raw, dif.pp_raw, dif.pa_raw} = v;
    endtask

    task automatic do_reset();
        set_raw(7'd0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        set_raw(7'h7f);
        reset = 1'b1;
        tick(10);
        n_cmp++;
        if (outs() !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_hold: outs=%b required %b", outs(), 10'd0);
        end
        do_reset();
        dif.m_raw = 1'b1;
        tick(8);
        dif.pa_raw = 1'b1;
        tick(4);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_mid: outs=%b required %b", outs(), 10'd0);
        end
        tick(1);
        reset = 1'b0;
        tick(5);
        n_cmp++;
        if ({dif.pa, dif.m} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_edge5: pa,m=%b required 00", {dif.pa, dif.m});
        end
        tick(1);
        n_cmp++;
        if ({dif.pa, dif.m} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_edge6: pa,m=%b required 11", {dif.pa, dif.m});
        end
    endtask

    task automatic test_debounce();
        logic seen;
        do_reset();
        seen = 1'b0;
        dif.pa_raw = 1'b1;
        tick(3);
        dif.pa_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (dif.pa) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch: pa seen high=%b required 0", seen);
        end
        dif.pa_raw = 1'b1;
        tick(5);
        n_cmp++;
        if (dif.pa !== 1'b0) begin
            n_bad++;
            $display("FAIL pa_edge5: pa=%b required 0", dif.pa);
        end
        tick(1);
        n_cmp++;
        if (dif.pa !== 1'b1) begin
            n_bad++;
            $display("FAIL pa_edge6: pa=%b required 1", dif.pa);
        end
    endtask

    task automatic test_mo_pulse();
        int pulses;
        int at;
        do_reset();
        pulses = 0;
        at = 0;
        dif.mo_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick(1);
            if (dif.mo_pulse) begin
                pulses++;
                at = e;
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL mo_hold_count: pulses=%0d required 1", pulses);
        end
        n_cmp++;
        if (at !== 7) begin
            n_bad++;
            $display("FAIL mo_pulse_edge: edge=%0d required 7", at);
        end
        dif.mo_raw = 1'b0;
        tick(10);
        pulses = 0;
        for (int p = 0; p < 3; p++) begin
            dif.mo_raw = 1'b1;
            for (int i = 0; i < 6; i++) begin
                tick(1);
                if (dif.mo_pulse) pulses++;
            end
            dif.mo_raw = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick(1);
                if (dif.mo_pulse) pulses++;
            end
        end
        n_cmp++;
        if (pulses !== 3) begin
            n_bad++;
            $display("FAIL mo_three_presses: pulses=%0d required 3", pulses);
        end
    endtask

    task automatic test_lock();
        do_reset();
        dif.m_raw  = 1'b1;
        dif.pp_raw = 1'b1;
        tick(8);
        dif.lk_raw = 1'b1;
        tick(7);
        n_cmp++;
        if ({dif.lk, dif.lk_pending} !== 2'b01) begin
            n_bad++;
            $display("FAIL lock_pend: lk,lk_pending=%b required 01", {dif.lk, dif.lk_pending});
        end
        dif.pp_raw = 1'b0;
        tick(6);
        n_cmp++;
        if ({dif.pp, dif.lk} !== 2'b00) begin
            n_bad++;
            $display("FAIL lock_pp_low: pp,lk=%b required 00", {dif.pp, dif.lk});
        end
        tick(1);
        n_cmp++;
        if ({dif.lk, dif.lk_pending} !== 2'b10) begin
            n_bad++;
            $display("FAIL lock_grant: lk,lk_pending=%b required 10", {dif.lk, dif.lk_pending});
        end
        dif.pp_raw = 1'b1;
        tick(10);
        n_cmp++;
        if ({dif.pp, dif.lk} !== 2'b11) begin
            n_bad++;
            $display("FAIL lock_hold_pp: pp,lk=%b required 11", {dif.pp, dif.lk});
        end
        dif.lk_raw = 1'b0;
        tick(6);
        n_cmp++;
        if (dif.lk !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_release_edge6: lk=%b required 1", dif.lk);
        end
        tick(1);
        n_cmp++;
        if ({dif.lk, dif.lk_pending} !== 2'b00) begin
            n_bad++;
            $display("FAIL lock_release: lk,lk_pending=%b required 00", {dif.lk, dif.lk_pending});
        end
    endtask

    task automatic test_release_wins();
        logic seen;
        do_reset();
        seen = 1'b0;
        dif.m_raw  = 1'b1;
        dif.pp_raw = 1'b1;
        dif.lk_raw = 1'b1;
        tick(7);
        n_cmp++;
        if (dif.lk_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL race_pend: lk_pending=%b required 1", dif.lk_pending);
        end
        dif.lk_raw = 1'b0;
        dif.pp_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (dif.lk) seen = 1'b1;
        end
        n_cmp++;
        if ({seen, dif.lk_pending} !== 2'b00) begin
            n_bad++;
            $display("FAIL race_release: lk_seen,lk_pending=%b required 00", {seen, dif.lk_pending});
        end
    endtask

    task automatic test_limit_fault();
        do_reset();
        dif.m_raw = 1'b1;
        dif.r_raw = 1'b1;
        tick(7);
        dif.m_raw = 1'b0;
        dif.r_raw = 1'b0;
        tick(12);
        n_cmp++;
        if (dif.limit_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_7: limit_fault=%b required 0", dif.limit_fault);
        end
        dif.m_raw = 1'b1;
        dif.r_raw = 1'b1;
        tick(8);
        dif.m_raw = 1'b0;
        dif.r_raw = 1'b0;
        tick(12);
        n_cmp++;
        if ({dif.m, dif.r, dif.limit_fault} !== 3'b001) begin
            n_bad++;
            $display("FAIL fault_8_sticky: m,r,limit_fault=%b required 001",
                     {dif.m, dif.r, dif.limit_fault});
        end
        do_reset();
        n_cmp++;
        if (dif.limit_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_reset: limit_fault=%b required 0", dif.limit_fault);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_raw(7'd0);
        test_reset();
        test_debounce();
        test_mo_pulse();
        test_lock();
        test_release_wins();
        test_limit_fault();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
